// File: rtl/bist_pkg.sv
// Shared types and defaults for the ALU BIST engine.
// Optional per-vector compare is enabled by defining BIST_VECTOR_CMP_EN.
package bist_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } bist_state_e;

  // Response word and MISR are one bit wider than the operands (carry).
  function automatic int unsigned resp_width(input int unsigned width);
    return width + 1;
  endfunction

  localparam logic [7:0]  DEF_LFSR_POLY = 8'hB8;
  localparam logic [8:0]  DEF_MISR_POLY = 9'h11D;
  localparam logic [7:0]  DEF_SEED_A    = 8'h01;
  localparam logic [7:0]  DEF_SEED_B    = 8'h5A;
  localparam int unsigned IDX_W         = 16;

endpackage

// File: rtl/bist_lfsr.sv
// Fibonacci-style operand LFSR with seed load; a zero seed is replaced by 1
// so the register can never lock up in the all-zero state.
module bist_lfsr #(
  parameter int unsigned       WIDTH = 8,
  parameter logic [WIDTH-1:0]  POLY  = 8'hB8,
  parameter logic [WIDTH-1:0]  SEED  = 8'h01
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic             i_advance,
  output logic [WIDTH-1:0] o_q
);

  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_load) begin
      r_q <= SEED_EFF;
    end else if (i_advance) begin
      r_q <= {r_q[WIDTH-2:0], ^(r_q & POLY)};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/bist_misr_controller.sv
// ALU self-test master: LFSR operands, cycling opcode, MISR compaction and
// golden-signature check. Define BIST_VECTOR_CMP_EN for per-vector compare.
module bist_misr_controller
  import bist_pkg::*;
#(
  parameter int unsigned       WIDTH        = 8,
  parameter int unsigned       SEL_W        = 4,
  parameter int unsigned       NUM_PATTERNS = 256,
  parameter int unsigned       DUT_LAT      = 0,
  parameter logic [WIDTH-1:0]  LFSR_POLY    = DEF_LFSR_POLY,
  parameter logic [WIDTH-1:0]  SEED_A       = DEF_SEED_A,
  parameter logic [WIDTH-1:0]  SEED_B       = DEF_SEED_B,
  parameter logic [WIDTH:0]    MISR_POLY    = DEF_MISR_POLY,
  parameter logic [WIDTH:0]    GOLDEN_SIG   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             carry_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   signature
`ifdef BIST_VECTOR_CMP_EN
  ,
  input  logic [WIDTH:0]   exp_data,
  output logic             fail_seen,
  output logic [IDX_W-1:0] first_fail_idx
`endif
);

  localparam int unsigned RW    = resp_width(WIDTH);
  localparam int unsigned CNT_W = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;

  bist_state_e      r_state;
  logic [SEL_W-1:0] r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_drain;
  logic [RW-1:0]    r_sig;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;

  logic             w_launch;
  logic             w_run;
  logic             w_last;
  logic             w_drain_last;
  logic             w_enter_done;
  logic             w_valid;
  logic [RW-1:0]    w_resp;
  logic [RW-1:0]    w_sig_next;
  logic [RW-1:0]    w_sig_final;
  logic             w_pass;

  assign w_run        = (r_state == S_RUN);
  assign w_launch     = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last       = w_run && (r_cnt == CNT_W'(NUM_PATTERNS - 1));
  assign w_drain_last = (r_state == S_DRAIN) && (r_drain == 2'(DUT_LAT - 1));
  assign w_enter_done = (w_last && (DUT_LAT == 0)) || w_drain_last;

  bist_lfsr #(.WIDTH(WIDTH), .POLY(LFSR_POLY), .SEED(SEED_A)) u_lfsr_a (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_load   (w_launch),
    .i_advance(w_run),
    .o_q      (a)
  );

  bist_lfsr #(.WIDTH(WIDTH), .POLY(LFSR_POLY), .SEED(SEED_B)) u_lfsr_b (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_load   (w_launch),
    .i_advance(w_run),
    .o_q      (b)
  );

  // Marks the cycles in which alu_out/carry_out belong to a presented vector.
  generate
    if (DUT_LAT == 0) begin : g_valid_now
      assign w_valid = w_run;
    end else begin : g_valid_pipe
      logic [DUT_LAT-1:0] r_vpipe;
      always_ff @(posedge clk) begin
        if (reset) begin
          r_vpipe <= '0;
        end else begin
          r_vpipe <= DUT_LAT'({r_vpipe, w_run});
        end
      end
      assign w_valid = r_vpipe[DUT_LAT-1];
    end
  endgenerate

  assign w_resp      = {alu_out, carry_out};
  assign w_sig_next  = {r_sig[RW-2:0], 1'b0} ^ (r_sig[RW-1] ? MISR_POLY : '0) ^ w_resp;
  // Final compaction and DONE entry can share an edge, so judge the next value.
  assign w_sig_final = w_valid ? w_sig_next : r_sig;

`ifdef BIST_VECTOR_CMP_EN
  logic             r_fail_seen;
  logic [IDX_W-1:0] r_first_idx;
  logic [IDX_W-1:0] r_resp_idx;
  logic             w_mis;

  assign w_mis  = w_valid && (w_resp != exp_data);
  assign w_pass = (w_sig_final == GOLDEN_SIG) && !(r_fail_seen || w_mis);

  always_ff @(posedge clk) begin
    if (reset || w_launch) begin
      r_fail_seen <= 1'b0;
      r_first_idx <= '0;
      r_resp_idx  <= '0;
    end else if (w_valid) begin
      r_resp_idx <= r_resp_idx + IDX_W'(1);
      if (w_mis && !r_fail_seen) begin
        r_fail_seen <= 1'b1;
        r_first_idx <= r_resp_idx;
      end
    end
  end

  assign fail_seen      = r_fail_seen;
  assign first_fail_idx = r_first_idx;
`else
  assign w_pass = (w_sig_final == GOLDEN_SIG);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_drain <= '0;
      r_sig   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      if (w_valid) begin
        r_sig <= w_sig_next;
      end
      if (w_enter_done) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
        r_pass <= w_pass;
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_RUN;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_sig   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end
        end
        S_RUN: begin
          r_sel <= r_sel + SEL_W'(1);
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_drain <= '0;
            r_state <= (DUT_LAT == 0) ? S_DONE : S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_drain <= r_drain + 2'(1);
          if (w_drain_last) begin
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign alu_sel   = r_sel;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign signature = r_sig;

endmodule

// File: tb/tb_bist_misr_controller.sv
// Bench for bist_misr_controller: latency-0 and latency-2 instances, table of
// runs plus reset/restart sequences. Honours BIST_VECTOR_CMP_EN when defined.
module tb_bist_misr_controller;

  localparam int unsigned NP = 4;

  function automatic logic [7:0] lfsr_step(input logic [7:0] x);
    return {x[6:0], ^(x & 8'hB8)};
  endfunction

  function automatic logic [8:0] misr_step(input logic [8:0] s, input logic [8:0] r);
    logic [8:0] t;
    t = {s[7:0], 1'b0};
    if (s[8]) t = t ^ 9'h11D;
    return t ^ r;
  endfunction

  // Reference ALU: {result, carry/borrow}
  function automatic logic [8:0] alu_f(input logic [7:0] x, input logic [7:0] y,
                                       input logic [3:0] s);
    logic [8:0] t;
    case (s[1:0])
      2'd0:    t = {1'b0, x} + {1'b0, y};
      2'd1:    t = {1'b0, x} - {1'b0, y};
      2'd2:    t = {1'b0, x & y};
      default: t = {1'b0, x ^ y};
    endcase
    return {t[7:0], t[8]};
  endfunction

  function automatic logic [8:0] model_sig(input int n);
    logic [7:0] la;
    logic [7:0] lb;
    logic [3:0] s;
    logic [8:0] sg;
    la = 8'h01; lb = 8'h5A; s = 4'd0; sg = 9'd0;
    for (int i = 0; i < n; i++) begin
      sg = misr_step(sg, alu_f(la, lb, s));
      la = lfsr_step(la);
      lb = lfsr_step(lb);
      s  = s + 4'd1;
    end
    return sg;
  endfunction

  localparam logic [8:0] GOLDEN1 = model_sig(NP);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [7:0] a0, b0, a1, b1;
  logic [3:0] sel0, sel1;
  logic [7:0] alu_out0 = 8'h00;
  logic       carry0 = 1'b0;
  logic [7:0] alu_out1;
  logic       carry1;
  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [8:0] sig0, sig1;
  logic [8:0] st1 = '0, st2 = '0;
`ifdef BIST_VECTOR_CMP_EN
  logic [8:0]  exp0 = '0, exp1 = '0;
  logic        fs0, fs1;
  logic [15:0] ffi0, ffi1;
`endif

  always #5 clk = ~clk;

  bist_misr_controller #(
    .WIDTH(8), .SEL_W(4), .NUM_PATTERNS(NP), .DUT_LAT(0), .LFSR_POLY(8'hB8),
    .SEED_A(8'h01), .SEED_B(8'h5A), .MISR_POLY(9'h11D), .GOLDEN_SIG(9'h000)
  ) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .a(a0), .b(b0), .alu_sel(sel0),
    .alu_out(alu_out0), .carry_out(carry0), .busy(busy0), .done(done0),
    .pass(pass0), .signature(sig0)
`ifdef BIST_VECTOR_CMP_EN
    , .exp_data(exp0), .fail_seen(fs0), .first_fail_idx(ffi0)
`endif
  );

  bist_misr_controller #(
    .WIDTH(8), .SEL_W(4), .NUM_PATTERNS(NP), .DUT_LAT(2), .LFSR_POLY(8'hB8),
    .SEED_A(8'h00), .SEED_B(8'h5A), .MISR_POLY(9'h11D), .GOLDEN_SIG(GOLDEN1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .alu_sel(sel1),
    .alu_out(alu_out1), .carry_out(carry1), .busy(busy1), .done(done1),
    .pass(pass1), .signature(sig1)
`ifdef BIST_VECTOR_CMP_EN
    , .exp_data(exp1), .fail_seen(fs1), .first_fail_idx(ffi1)
`endif
  );

  // Two-stage registered ALU behind the latency-2 instance.
  always @(posedge clk) begin
    st1 <= alu_f(a1, b1, sel1);
    st2 <= st1;
  end
  assign alu_out1 = st2[8:1];
  assign carry1   = st2[0];
`ifdef BIST_VECTOR_CMP_EN
  always_comb exp1 = st2;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
  } vec_t;

  typedef struct {
    int         flip;
    int         eflip;
    int         restart;
    logic [8:0] sig;
    logic       pass;
  } row_t;

  vec_t sb[$];
  row_t rows[5];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_vectors();
    logic [7:0] la;
    logic [7:0] lb;
    la = 8'h01;
    lb = 8'h5A;
    for (int i = 0; i < int'(NP); i++) begin
      sb.push_back('{a: la, b: lb, sel: 4'(i)});
      la = lfsr_step(la);
      lb = lfsr_step(lb);
    end
  endtask

  task automatic pop_check();
    vec_t v;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_underflow: got empty queue expected a vector at %0t", $time);
    end else begin
      v = sb.pop_front();
      chk("vec_a", 32'(a0), 32'(v.a));
      chk("vec_b", 32'(b0), 32'(v.b));
      chk("vec_sel", 32'(sel0), 32'(v.sel));
    end
  endtask

  // Entered #1 after an edge with dut0 idle or done.
  task automatic run0(input row_t r);
    start0 = 1'b1;
    push_vectors();
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int i = 0; i < int'(NP); i++) begin
      carry0 = (i == r.flip);
`ifdef BIST_VECTOR_CMP_EN
      exp0 = {8'h00, (i == r.flip) ^ (i == r.eflip)};
`endif
      if (i == r.restart) start0 = 1'b1;
      @(negedge clk);
      pop_check();
      chk("run_busy", 32'(busy0), 32'd1);
      if (i == 0) begin
        chk("run_done_clr", 32'(done0), 32'd0);
        chk("run_pass_clr", 32'(pass0), 32'd0);
      end
      @(posedge clk); #1;
      start0 = 1'b0;
    end
    carry0 = 1'b0;
    @(negedge clk);
    chk("end_done", 32'(done0), 32'd1);
    chk("end_busy", 32'(busy0), 32'd0);
    chk("end_sig", 32'(sig0), 32'(r.sig));
    chk("end_pass", 32'(pass0), 32'(r.pass));
`ifdef BIST_VECTOR_CMP_EN
    chk("fail_seen", 32'(fs0), 32'(r.eflip >= 0));
    chk("first_fail_idx", 32'(ffi0), (r.eflip >= 0) ? 32'(r.eflip) : 32'd0);
`endif
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_done", 32'(done0), 32'd1);
    chk("hold_busy", 32'(busy0), 32'd0);
    chk("hold_sig", 32'(sig0), 32'(r.sig));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [8:0] s;
    rows[0] = '{flip: -1, eflip: -1, restart: -1, sig: '0, pass: 1'b0};
    rows[1] = '{flip:  2, eflip: -1, restart: -1, sig: '0, pass: 1'b0};
    rows[2] = '{flip: -1, eflip: -1, restart:  1, sig: '0, pass: 1'b0};
    rows[3] = '{flip:  0, eflip: -1, restart:  3, sig: '0, pass: 1'b0};
    rows[4] = '{flip: -1, eflip:  2, restart: -1, sig: '0, pass: 1'b0};
    foreach (rows[k]) begin
      s = '0;
      for (int i = 0; i < int'(NP); i++) s = misr_step(s, {8'h00, i == rows[k].flip});
      rows[k].sig  = s;
      rows[k].pass = (s == 9'h000);
`ifdef BIST_VECTOR_CMP_EN
      if (rows[k].eflip >= 0) rows[k].pass = 1'b0;
`endif
    end

    // Reset state, sampled while reset is still asserted.
    @(posedge clk);
    @(negedge clk);
    chk("rst_a", 32'(a0), 32'h01);
    chk("rst_b", 32'(b0), 32'h5A);
    chk("rst_sel", 32'(sel0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_pass", 32'(pass0), 32'd0);
    chk("rst_sig", 32'(sig0), 32'd0);
    chk("rst_seed0_a", 32'(a1), 32'h01);
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (rows[k]) run0(rows[k]);

    // Reset in the middle of vector 2, then rerun the carry-flip case.
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    @(posedge clk); #1;
    carry0 = 1'b1;
    @(posedge clk); #1;
    carry0 = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_a", 32'(a0), 32'h01);
    chk("mid_rst_sel", 32'(sel0), 32'd0);
    chk("mid_rst_busy", 32'(busy0), 32'd0);
    chk("mid_rst_done", 32'(done0), 32'd0);
    chk("mid_rst_sig", 32'(sig0), 32'd0);
    @(posedge clk); #1;
    run0(rows[1]);

    // Latency-2 instance against the registered ALU model.
    chk("lat2_golden_nonzero", 32'(GOLDEN1 != 9'h000), 32'd1);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int c = 0; c < int'(NP) + 2; c++) begin
      @(negedge clk);
      chk("lat2_busy", 32'(busy1), 32'd1);
      chk("lat2_done_early", 32'(done1), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("lat2_done", 32'(done1), 32'd1);
    chk("lat2_busy_end", 32'(busy1), 32'd0);
    chk("lat2_sig", 32'(sig1), 32'(GOLDEN1));
    chk("lat2_pass", 32'(pass1), 32'd1);
`ifdef BIST_VECTOR_CMP_EN
    chk("lat2_fail_seen", 32'(fs1), 32'd0);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
